calculadora_display: RTL

- Consumer of the calculator's output: takes the 14-bit unsigned magnitude `result` and the negative flag `signal`.
- Converts the magnitude to 5 BCD digits with an iterative shift-add-3 (double-dabble) engine.
- Drives six seven-segment displays: five digits plus a minus sign.
- Sits between the calculator core and the board's HEX displays, with a busy/valid status handshake.

---
 rtl/calc_pkg.sv | 15 +
 rtl/bcd_to_7seg.sv | 10 +
 rtl/calculadora_display.sv | 125 ++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM states, segment codes and width defaults for the calculator display path.
package calc_pkg;
  localparam int W_IN_DEF = 14;
  localparam int NDIG_DEF = 5;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  // active-low gfedcba, codes 10..15 never occur and are shown blank
  localparam logic [0:15][6:0] SEG_TABLE = {
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, SEG_BLANK, SEG_BLANK,
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK
  };
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: one BCD nibble to active-low gfedcba segments, with a blanking override.
module bcd_to_7seg
  import calc_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);
  assign seg_o = blank_i ? SEG_BLANK : SEG_TABLE[nib_i];
endmodule

// File: rtl/calculadora_display.sv
// calculadora_display: double-dabble conversion of the calculator result onto five digits plus a sign display.
module calculadora_display
  import calc_pkg::*;
#(
  parameter int W_IN           = W_IN_DEF,
  parameter int NDIG           = NDIG_DEF,
  parameter bit BLANK_ZEROS    = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_IN-1:0]   result,
  input  logic              signal,
  output logic [4*NDIG-1:0] bcd,
  output logic              neg,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3,
  output logic [6:0]        hex4,
  output logic [6:0]        hex5,
  output logic              busy,
  output logic              valid
);
  localparam int SW = 4*NDIG + W_IN;
  localparam int CW = $clog2(W_IN + 1);
  state_t                   state_q, state_d;
  logic [W_IN:0]            last_q, last_d;
  logic                     have_q, have_d;
  logic [SW-1:0]            sh_q, sh_d, add3;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [4*NDIG-1:0]        bcd_q, bcd_d, conv;
  logic                     neg_q, neg_d, busy_q, busy_d, valid_q, valid_d;
  logic [NDIG-1:0][6:0]     seg_q, seg_d, seg_w;
  logic [6:0]               sgn_q, sgn_d;
  assign conv = sh_q[SW-1:W_IN];
  for (genvar d = 0; d < NDIG; d++) begin : g_dig
    bcd_to_7seg u_seg (
      .nib_i  (conv[4*d +: 4]),
      .blank_i((d > 0) && BLANK_ZEROS && (conv[4*NDIG-1:4*d] == '0)),
      .seg_o  (seg_w[d])
    );
  end
  always_comb begin
    add3 = sh_q;
    for (int k = 0; k < NDIG; k++)
      if (add3[W_IN+4*k +: 4] >= 4'd5) add3[W_IN+4*k +: 4] = add3[W_IN+4*k +: 4] + 4'd3;
  end
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    have_d  = have_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    seg_d   = seg_q;
    sgn_d   = sgn_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (!have_q || {signal, result} != last_q) begin
        last_d  = {signal, result};
        have_d  = 1'b1;
        sh_d    = {{(4*NDIG){1'b0}}, result};
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        sh_d    = add3 << 1;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(W_IN - 1)) ? DONE : SHIFT;
      end
      DONE: begin
        // negative zero is displayed and reported as plain zero
        bcd_d   = conv;
        neg_d   = last_q[W_IN] && (conv != '0);
        seg_d   = seg_w;
        sgn_d   = neg_d ? SEG_MINUS : SEG_BLANK;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= '0;
      have_q  <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      seg_q   <= {NDIG{SEG_BLANK}};
      sgn_q   <= SEG_BLANK;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      have_q  <= have_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      seg_q   <= seg_d;
      sgn_q   <= sgn_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end
  assign bcd   = bcd_q;
  assign neg   = neg_q;
  assign busy  = busy_q;
  assign valid = valid_q;
  assign hex0  = SEG_ACTIVE_LOW ? seg_q[0] : ~seg_q[0];
  assign hex1  = SEG_ACTIVE_LOW ? seg_q[1] : ~seg_q[1];
  assign hex2  = SEG_ACTIVE_LOW ? seg_q[2] : ~seg_q[2];
  assign hex3  = SEG_ACTIVE_LOW ? seg_q[3] : ~seg_q[3];
  assign hex4  = SEG_ACTIVE_LOW ? seg_q[4] : ~seg_q[4];
  assign hex5  = SEG_ACTIVE_LOW ? sgn_q : ~sgn_q;
endmodule
